hw_barrier_array: RTL and testbench

//  NB_BARR hardware barriers in one block with a private register port; successor to the per-barrier unit in the event unit.

---
 rtl/hw_barrier_pkg.sv | 24 ++
 rtl/hw_barrier_slot.sv | 75 +++++++
 rtl/hw_barrier_array.sv | 105 ++++++++++
 tb/tb_hw_barrier_array.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hw_barrier_pkg.sv
// Shared register indices, config record and popcount helper for the hardware barrier array.
// Pure declarations: no latency, no flow control.
package hw_barrier_pkg;

   localparam logic [2:0] BARR_STATUS = 3'd0;
   localparam logic [2:0] BARR_PART   = 3'd1;
   localparam logic [2:0] BARR_TARGET = 3'd2;
   localparam logic [2:0] BARR_THRESH = 3'd3;
   localparam logic [2:0] BARR_GEN    = 3'd4;

   typedef struct packed {
      logic [31:0] part;
      logic [31:0] target;
      logic [5:0]  thresh;
   } barr_cfg_t;

   function automatic logic [5:0] popcount32(input logic [31:0] v);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/hw_barrier_slot.sv
// One barrier: arrival mask, config, generation counter; event registered 1 cycle after the completing trigger.
// No backpressure: triggers are always accepted, a same-cycle cfg write takes priority and drops them.
module hw_barrier_slot
   import hw_barrier_pkg::*;
#(
   parameter int NB_CORES = 8,
   parameter int GEN_W    = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NB_CORES-1:0] trig,
   input  logic                cfg_we,
   input  logic [2:0]          cfg_reg,
   input  logic [31:0]         cfg_wdata,
   output logic [NB_CORES-1:0] status,
   output barr_cfg_t           cfg,
   output logic [GEN_W-1:0]    gen,
   output logic [NB_CORES-1:0] evt,
   output logic                busy
);

   localparam logic [31:0] CORE_MASK = (NB_CORES >= 32) ? 32'hFFFF_FFFF
                                                        : ((32'd1 << NB_CORES) - 32'd1);

   logic [NB_CORES-1:0] part_m;
   logic [NB_CORES-1:0] target_m;
   logic [NB_CORES-1:0] arr;
   logic [NB_CORES-1:0] nxt;
   logic [5:0]          cnt;
   logic                hit;
   logic                full;
   logic                done;

   assign part_m   = cfg.part[NB_CORES-1:0];
   assign target_m = cfg.target[NB_CORES-1:0];
   assign arr      = trig & part_m;
   assign nxt      = status | arr;
   assign hit      = |arr;
   assign cnt      = popcount32(32'(nxt));
   assign full     = (part_m != '0) && (nxt == part_m);
   // Completion is only evaluated when a participant actually arrives.
   assign done     = hit && !cfg_we && ((cfg.thresh == 6'd0) ? full : (cnt >= cfg.thresh));
   assign busy     = |status;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         status <= '0;
         cfg    <= '0;
         gen    <= '0;
         evt    <= '0;
      end else begin
         evt <= '0;
         if (cfg_we) begin
            case (cfg_reg)
               BARR_STATUS: status <= '0;
               BARR_PART: begin
                  cfg.part <= cfg_wdata & CORE_MASK;
                  status   <= '0;
               end
               BARR_TARGET: cfg.target <= cfg_wdata & CORE_MASK;
               BARR_THRESH: cfg.thresh <= cfg_wdata[5:0];
               default: ;
            endcase
         end else if (done) begin
            // Surplus arrivals in the completing cycle are absorbed here.
            status <= '0;
            gen    <= gen + 1'b1;
            evt    <= target_m;
         end else begin
            status <= nxt;
         end
      end
   end

endmodule

// File: rtl/hw_barrier_array.sv
// NB_BARR hardware barriers with cfg decode, trigger/event transpose and registered cfg response.
// Grant is combinational (never stalls); response valid and read data 1 cycle after grant.
module hw_barrier_array
   import hw_barrier_pkg::*;
#(
   parameter int NB_CORES = 8,
   parameter int NB_BARR  = 8,
   parameter int GEN_W    = 8,
   parameter int ADDR_W   = 10
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [NB_CORES-1:0][NB_BARR-1:0]  trig_i,
   output logic [NB_CORES-1:0][NB_BARR-1:0]  barr_evt_o,
   output logic [NB_BARR-1:0]                barr_busy_o,
   input  logic                              cfg_req_i,
   input  logic                              cfg_wen_i,
   input  logic [ADDR_W-1:0]                 cfg_add_i,
   input  logic [31:0]                       cfg_wdata_i,
   output logic                              cfg_gnt_o,
   output logic                              cfg_r_valid_o,
   output logic [31:0]                       cfg_r_rdata_o
);

   localparam int IDX_W = ADDR_W - 5;

   logic [IDX_W-1:0]    barr_idx;
   logic [2:0]          reg_idx;
   logic                in_range;
   logic [31:0]         rd_dat;
   logic                unused_addr;

   logic [NB_CORES-1:0] trig_t   [NB_BARR];
   logic [NB_CORES-1:0] evt_t    [NB_BARR];
   logic [NB_CORES-1:0] status_a [NB_BARR];
   barr_cfg_t           cfg_a    [NB_BARR];
   logic [GEN_W-1:0]    gen_a    [NB_BARR];
   logic [NB_BARR-1:0]  slot_we;

   assign barr_idx    = cfg_add_i[ADDR_W-1:5];
   assign reg_idx     = cfg_add_i[4:2];
   assign in_range    = (32'(barr_idx) < 32'(NB_BARR));
   assign unused_addr = ^cfg_add_i[1:0];
   assign cfg_gnt_o   = cfg_req_i;

   always_comb begin
      for (int b = 0; b < NB_BARR; b++)
         for (int c = 0; c < NB_CORES; c++)
            trig_t[b][c] = trig_i[c][b];
   end

   always_comb begin
      for (int c = 0; c < NB_CORES; c++)
         for (int b = 0; b < NB_BARR; b++)
            barr_evt_o[c][b] = evt_t[b][c];
   end

   for (genvar b = 0; b < NB_BARR; b++) begin : g_slot
      assign slot_we[b] = cfg_req_i && !cfg_wen_i && in_range && (32'(barr_idx) == 32'(b));

      hw_barrier_slot #(
         .NB_CORES (NB_CORES),
         .GEN_W    (GEN_W)
      ) u_slot (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .trig      (trig_t[b]),
         .cfg_we    (slot_we[b]),
         .cfg_reg   (reg_idx),
         .cfg_wdata (cfg_wdata_i),
         .status    (status_a[b]),
         .cfg       (cfg_a[b]),
         .gen       (gen_a[b]),
         .evt       (evt_t[b]),
         .busy      (barr_busy_o[b])
      );
   end

   always_comb begin
      rd_dat = '0;
      for (int b = 0; b < NB_BARR; b++) begin
         if (in_range && (32'(barr_idx) == 32'(b))) begin
            case (reg_idx)
               BARR_STATUS: rd_dat = 32'(status_a[b]);
               BARR_PART:   rd_dat = cfg_a[b].part;
               BARR_TARGET: rd_dat = cfg_a[b].target;
               BARR_THRESH: rd_dat = 32'(cfg_a[b].thresh);
               BARR_GEN:    rd_dat = 32'(gen_a[b]);
               default:     rd_dat = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cfg_r_valid_o <= 1'b0;
         cfg_r_rdata_o <= '0;
      end else begin
         cfg_r_valid_o <= cfg_req_i;
         cfg_r_rdata_o <= (cfg_req_i && cfg_wen_i) ? rd_dat : '0;
      end
   end

endmodule

// File: tb/tb_hw_barrier_array.sv
// Directed bench for hw_barrier_array: hand-computed expectations checked with immediate assertions.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_hw_barrier_array;

   localparam int NB_CORES = 8;
   localparam int NB_BARR  = 8;
   localparam int GEN_W    = 8;
   localparam int ADDR_W   = 10;

   logic                             clk_i;
   logic                             rst_ni;
   logic [NB_CORES-1:0][NB_BARR-1:0] trig_i;
   logic [NB_CORES-1:0][NB_BARR-1:0] barr_evt_o;
   logic [NB_BARR-1:0]               barr_busy_o;
   logic                             cfg_req_i;
   logic                             cfg_wen_i;
   logic [ADDR_W-1:0]                cfg_add_i;
   logic [31:0]                      cfg_wdata_i;
   logic                             cfg_gnt_o;
   logic                             cfg_r_valid_o;
   logic [31:0]                      cfg_r_rdata_o;

   int n_tests = 0;
   int n_fail  = 0;

   hw_barrier_array #(
      .NB_CORES (NB_CORES),
      .NB_BARR  (NB_BARR),
      .GEN_W    (GEN_W),
      .ADDR_W   (ADDR_W)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .trig_i        (trig_i),
      .barr_evt_o    (barr_evt_o),
      .barr_busy_o   (barr_busy_o),
      .cfg_req_i     (cfg_req_i),
      .cfg_wen_i     (cfg_wen_i),
      .cfg_add_i     (cfg_add_i),
      .cfg_wdata_i   (cfg_wdata_i),
      .cfg_gnt_o     (cfg_gnt_o),
      .cfg_r_valid_o (cfg_r_valid_o),
      .cfg_r_rdata_o (cfg_r_rdata_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [ADDR_W-1:0] addr(input int b, input int r);
      return ADDR_W'(b * 32 + r * 4);
   endfunction

   task automatic cfg_write(input int b, input int r, input logic [31:0] d);
      cfg_req_i   = 1'b1;
      cfg_wen_i   = 1'b0;
      cfg_add_i   = addr(b, r);
      cfg_wdata_i = d;
      tick();
      check("wr_rvalid", 64'(cfg_r_valid_o), 64'd1);
      check("wr_rdata", 64'(cfg_r_rdata_o), 64'd0);
      cfg_req_i   = 1'b0;
      cfg_wdata_i = '0;
   endtask

   task automatic rd_check(input string tag, input int b, input int r, input logic [31:0] exp);
      cfg_req_i = 1'b1;
      cfg_wen_i = 1'b1;
      cfg_add_i = addr(b, r);
      #1;
      check("gnt", 64'(cfg_gnt_o), 64'd1);
      tick();
      check("rd_rvalid", 64'(cfg_r_valid_o), 64'd1);
      check(tag, 64'(cfg_r_rdata_o), 64'(exp));
      cfg_req_i = 1'b0;
   endtask

   initial begin
      rst_ni      = 1'b0;
      trig_i      = '0;
      cfg_req_i   = 1'b0;
      cfg_wen_i   = 1'b1;
      cfg_add_i   = '0;
      cfg_wdata_i = '0;
      tick();
      tick();
      check("rst_evt", 64'(barr_evt_o), 64'd0);
      check("rst_busy", 64'(barr_busy_o), 64'd0);
      check("rst_rvalid", 64'(cfg_r_valid_o), 64'd0);
      check("rst_rdata", 64'(cfg_r_rdata_o), 64'd0);
      rst_ni = 1'b1;
      tick();

      // 1: full barrier on b0, cores 0..3 arrive one per cycle
      cfg_write(0, 1, 32'h0F);
      cfg_write(0, 2, 32'hFF);
      for (int c = 0; c < 4; c++) begin
         trig_i = '0;
         trig_i[c][0] = 1'b1;
         tick();
         if (c < 3) begin
            check("t1_no_evt", 64'(barr_evt_o), 64'd0);
            check("t1_busy", 64'(barr_busy_o), 64'h01);
         end else begin
            check("t1_evt", 64'(barr_evt_o), 64'h0101_0101_0101_0101);
         end
      end
      trig_i = '0;
      tick();
      check("t1_evt_1cyc", 64'(barr_evt_o), 64'd0);
      rd_check("t1_gen", 0, 4, 32'd1);
      rd_check("t1_status", 0, 0, 32'd0);

      // 2: count mode on b1, threshold 2, three arrivals at once
      cfg_write(1, 3, 32'd2);
      cfg_write(1, 1, 32'hFF);
      cfg_write(1, 2, 32'h22);
      trig_i = '0;
      trig_i[1][1] = 1'b1;
      trig_i[5][1] = 1'b1;
      trig_i[6][1] = 1'b1;
      tick();
      trig_i = '0;
      check("t2_evt", 64'(barr_evt_o), 64'h0000_0200_0000_0200);
      check("t2_busy", 64'(barr_busy_o), 64'h00);
      rd_check("t2_status", 1, 0, 32'd0);
      rd_check("t2_gen", 1, 4, 32'd1);

      // 3: non-participant and repeated triggers on b0
      cfg_write(0, 1, 32'h03);
      trig_i = '0;
      trig_i[7][0] = 1'b1;
      trig_i[0][0] = 1'b1;
      tick();
      check("t3_no_evt_a", 64'(barr_evt_o), 64'd0);
      trig_i = '0;
      trig_i[0][0] = 1'b1;
      tick();
      check("t3_no_evt_b", 64'(barr_evt_o), 64'd0);
      trig_i = '0;
      rd_check("t3_status", 0, 0, 32'h01);
      check("t3_busy", 64'(barr_busy_o), 64'h01);

      // 4: PART rewrite on b2 aborts, same-cycle trigger dropped
      cfg_write(2, 1, 32'h07);
      cfg_write(2, 2, 32'hFF);
      trig_i = '0;
      trig_i[0][2] = 1'b1;
      trig_i[1][2] = 1'b1;
      tick();
      trig_i = '0;
      check("t4_busy_pre", 64'(barr_busy_o), 64'h05);
      cfg_req_i    = 1'b1;
      cfg_wen_i    = 1'b0;
      cfg_add_i    = addr(2, 1);
      cfg_wdata_i  = 32'h03;
      trig_i[1][2] = 1'b1;
      tick();
      cfg_req_i    = 1'b0;
      trig_i       = '0;
      check("t4_no_evt", 64'(barr_evt_o), 64'd0);
      tick();
      check("t4_no_evt_late", 64'(barr_evt_o), 64'd0);
      rd_check("t4_status", 2, 0, 32'd0);
      rd_check("t4_gen", 2, 4, 32'd0);
      rd_check("t4_part", 2, 1, 32'h03);
      check("t4_busy_post", 64'(barr_busy_o), 64'h01);

      // 5: generation wrap on b3, plus unused-register and out-of-range accesses
      cfg_write(3, 1, 32'h01);
      trig_i = '0;
      trig_i[0][3] = 1'b1;
      for (int i = 0; i < 255; i++) tick();
      trig_i = '0;
      rd_check("t5_gen_255", 3, 4, 32'hFF);
      trig_i[0][3] = 1'b1;
      tick();
      trig_i = '0;
      rd_check("t5_gen_wrap", 3, 4, 32'd0);
      rd_check("t5_reg6", 0, 6, 32'd0);
      rd_check("t5_oor_status", NB_BARR, 0, 32'd0);
      rd_check("t5_oor_part", NB_BARR, 1, 32'd0);
      cfg_write(NB_BARR, 1, 32'hF0);
      rd_check("t5_part_kept", 0, 1, 32'h03);
      tick();
      check("t5_rvalid_drop", 64'(cfg_r_valid_o), 64'd0);

      // 6: reset in the middle of a barrier on b4
      cfg_write(4, 1, 32'h0F);
      cfg_write(4, 2, 32'hFF);
      trig_i = '0;
      trig_i[0][4] = 1'b1;
      trig_i[2][4] = 1'b1;
      tick();
      trig_i = '0;
      rd_check("t6_status_pre", 4, 0, 32'h05);
      rst_ni = 1'b0;
      trig_i[1][4] = 1'b1;
      trig_i[3][4] = 1'b1;
      cfg_req_i = 1'b1;
      cfg_wen_i = 1'b1;
      cfg_add_i = addr(4, 0);
      tick();
      check("t6_evt", 64'(barr_evt_o), 64'd0);
      check("t6_busy", 64'(barr_busy_o), 64'd0);
      check("t6_rvalid", 64'(cfg_r_valid_o), 64'd0);
      check("t6_rdata", 64'(cfg_r_rdata_o), 64'd0);
      rst_ni    = 1'b1;
      trig_i    = '0;
      cfg_req_i = 1'b0;
      tick();
      check("t6_evt_after", 64'(barr_evt_o), 64'd0);
      rd_check("t6_status", 4, 0, 32'd0);
      rd_check("t6_part", 4, 1, 32'd0);
      rd_check("t6_target", 4, 2, 32'd0);
      rd_check("t6_gen0", 0, 4, 32'd0);
      rd_check("t6_thresh1", 1, 3, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
